// File: rtl/minmax_win_if.sv
// minmax_win_if: sample stream, window control and snapshot bus for the windowed min/max tracker
interface minmax_win_if #(
    parameter int width = 14,
    parameter int nch   = 4,
    parameter int chw   = 2,
    parameter int pw    = 16
);
    logic [width-1:0]         xin;
    logic                     xin_valid;
    logic [chw-1:0]           xin_ch;
    logic [pw-1:0]            period;
    logic                     clear;
    logic [nch*width-1:0]     xmin;
    logic [nch*width-1:0]     xmax;
    logic [nch*(width+1)-1:0] xspan;
    logic [nch-1:0]           seen;
    logic                     done;
    modport master (output xin, xin_valid, xin_ch, period, clear,
                    input  xmin, xmax, xspan, seen, done);
    modport slave  (input  xin, xin_valid, xin_ch, period, clear,
                    output xmin, xmax, xspan, seen, done);
endinterface

// File: rtl/minmax_win.sv
// minmax_win: per-channel windowed min/max/span tracker with periodic snapshots
module minmax_win #(
    parameter int width       = 14,
    parameter int nch         = 4,
    parameter int chw         = 2,
    parameter int pw          = 16,
    parameter int signed_mode = 1
) (
    input logic          clk,
    input logic          reset_n,
    minmax_win_if.slave  bus
);
    logic [pw-1:0]            cnt_q;
    logic [nch-1:0]           seen_acc_q, seen_acc_d;
    logic [width-1:0]         min_q [nch];
    logic [width-1:0]         max_q [nch];
    logic [width-1:0]         min_d [nch];
    logic [width-1:0]         max_d [nch];
    logic [width:0]           span_d [nch];
    logic [nch*width-1:0]     xmin_q, xmax_q;
    logic [nch*(width+1)-1:0] xspan_q;
    logic [nch-1:0]           seen_q;
    logic                     done_q;
    logic                     win_end;

    function automatic logic lt(input logic [width-1:0] a, input logic [width-1:0] b);
        return (signed_mode != 0) ? ($signed(a) < $signed(b)) : (a < b);
    endfunction

    function automatic logic [width:0] ext(input logic [width-1:0] a);
        return (signed_mode != 0) ? {a[width-1], a} : {1'b0, a};
    endfunction

    // >= rather than == so a period lowered below the running count still closes the window
    assign win_end = cnt_q >= bus.period;

    // next accumulator state with this cycle's sample folded in; the seen bit stands in for sentinels
    always_comb begin
        for (int k = 0; k < nch; k++) begin
            logic hit;
            hit = bus.xin_valid && (bus.xin_ch == chw'(k));
            seen_acc_d[k] = seen_acc_q[k] | hit;
            min_d[k] = (hit && (!seen_acc_q[k] || lt(bus.xin, min_q[k]))) ? bus.xin : min_q[k];
            max_d[k] = (hit && (!seen_acc_q[k] || lt(max_q[k], bus.xin))) ? bus.xin : max_q[k];
            span_d[k] = ext(max_d[k]) - ext(min_d[k]);
        end
    end

    // window counter, accumulators and snapshot registers; clear aborts without touching snapshots
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            seen_acc_q <= '0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            xspan_q    <= '0;
            seen_q     <= '0;
            done_q     <= 1'b0;
            for (int k = 0; k < nch; k++) begin
                min_q[k] <= '0;
                max_q[k] <= '0;
            end
        end else if (bus.clear) begin
            cnt_q      <= '0;
            seen_acc_q <= '0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= win_end ? '0 : cnt_q + pw'(1);
            seen_acc_q <= win_end ? '0 : seen_acc_d;
            done_q     <= win_end;
            for (int k = 0; k < nch; k++) begin
                min_q[k] <= min_d[k];
                max_q[k] <= max_d[k];
            end
            if (win_end) begin
                seen_q <= seen_acc_d;
                for (int k = 0; k < nch; k++) begin
                    xmin_q[k*width +: width]          <= seen_acc_d[k] ? min_d[k] : '0;
                    xmax_q[k*width +: width]          <= seen_acc_d[k] ? max_d[k] : '0;
                    xspan_q[k*(width+1) +: (width+1)] <= seen_acc_d[k] ? span_d[k] : '0;
                end
            end
        end
    end

    assign bus.xmin  = xmin_q;
    assign bus.xmax  = xmax_q;
    assign bus.xspan = xspan_q;
    assign bus.seen  = seen_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_minmax_win.sv
// tb_minmax_win: directed checks of an unsigned and a signed minmax_win fed the same stimulus
module tb_minmax_win;
    localparam int W = 14;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  xin = '0;
    logic          xin_valid = 1'b0;
    logic [1:0]    xin_ch = '0;
    logic [15:0]   period = 16'd9;
    logic          clear = 1'b0;
    int            vecs = 0;
    int            errs = 0;

    always #5 clk = ~clk;

    minmax_win_if #(.width(W), .nch(N), .chw(2), .pw(16)) ifu ();
    minmax_win_if #(.width(W), .nch(N), .chw(2), .pw(16)) ifs ();

    assign ifu.xin = xin;
    assign ifu.xin_valid = xin_valid;
    assign ifu.xin_ch = xin_ch;
    assign ifu.period = period;
    assign ifu.clear = clear;
    assign ifs.xin = xin;
    assign ifs.xin_valid = xin_valid;
    assign ifs.xin_ch = xin_ch;
    assign ifs.period = period;
    assign ifs.clear = clear;

    minmax_win #(.width(W), .nch(N), .chw(2), .pw(16), .signed_mode(0)) du (
        .clk(clk), .reset_n(reset_n), .bus(ifu.slave));
    minmax_win #(.width(W), .nch(N), .chw(2), .pw(16), .signed_mode(1)) ds (
        .clk(clk), .reset_n(reset_n), .bus(ifs.slave));

    task automatic step(input logic v, input logic [1:0] ch, input logic [W-1:0] x, input logic clr);
        xin_valid = v;
        xin_ch = ch;
        xin = x;
        clear = clr;
        @(posedge clk);
        #1;
        xin_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n, output int d);
        d = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 2'd0, '0, 1'b0);
            d += int'(ifu.done);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #2;
        vecs++;
        if ({ifu.xmin, ifu.xmax, ifu.xspan, ifu.seen, ifu.done, ifs.xmin, ifs.seen, ifs.done} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got xmin=%h seen=%b done=%b exp all zero", ifu.xmin, ifu.seen, ifu.done);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned;
        int d;
        step(1'b1, 2'd0, 14'd100, 1'b0);
        step(1'b1, 2'd0, 14'd5, 1'b0);
        step(1'b1, 2'd0, 14'd16383, 1'b0);
        step(1'b1, 2'd1, 14'd7, 1'b0);
        idle(5, d);
        vecs++;
        if (d !== 0) begin errs++; $display("FAIL unsigned_early_done got %0d pulses exp 0", d); end
        step(1'b0, 2'd0, '0, 1'b0);
        vecs++;
        if (ifu.done !== 1'b1) begin errs++; $display("FAIL unsigned_done got %b exp 1", ifu.done); end
        vecs++;
        if (ifu.xmin !== {14'd0, 14'd0, 14'd7, 14'd5}) begin errs++; $display("FAIL unsigned_xmin got %h", ifu.xmin); end
        vecs++;
        if (ifu.xmax !== {14'd0, 14'd0, 14'd7, 14'd16383}) begin errs++; $display("FAIL unsigned_xmax got %h", ifu.xmax); end
        vecs++;
        if (ifu.xspan !== {15'd0, 15'd0, 15'd0, 15'd16378}) begin errs++; $display("FAIL unsigned_xspan got %h", ifu.xspan); end
        vecs++;
        if (ifu.seen !== 4'b0011) begin errs++; $display("FAIL unsigned_seen got %b exp 0011", ifu.seen); end
        vecs++;
        if ({ifs.xmin, ifs.xmax, ifs.xspan} !== {14'd0, 14'd0, 14'd7, 14'h3FFF, 14'd0, 14'd0, 14'd7, 14'd100,
                                                  15'd0, 15'd0, 15'd0, 15'd101}) begin
            errs++;
            $display("FAIL signed_mixed got min=%h max=%h span=%h", ifs.xmin, ifs.xmax, ifs.xspan);
        end
    endtask

    task automatic test_signed;
        int d;
        step(1'b1, 2'd3, 14'h2000, 1'b0);
        vecs++;
        if (ifu.done !== 1'b0) begin errs++; $display("FAIL done_one_cycle got %b exp 0", ifu.done); end
        step(1'b1, 2'd3, 14'h1FFF, 1'b0);
        step(1'b1, 2'd3, 14'h3FFF, 1'b0);
        idle(6, d);
        step(1'b0, 2'd0, '0, 1'b0);
        vecs++;
        if ({ifs.done, ifs.seen, ifs.xmin[55:42], ifs.xmax[55:42], ifs.xspan[59:45]} !==
            {1'b1, 4'b1000, 14'h2000, 14'h1FFF, 15'd16383}) begin
            errs++;
            $display("FAIL signed_ch3 got done=%b seen=%b min=%h max=%h span=%0d",
                     ifs.done, ifs.seen, ifs.xmin[55:42], ifs.xmax[55:42], ifs.xspan[59:45]);
        end
        vecs++;
        if ({ifu.xmin, ifu.xmax, ifu.xspan} !== {14'h1FFF, 42'd0, 14'h3FFF, 42'd0, 15'd8192, 45'd0}) begin
            errs++;
            $display("FAIL unsigned_ch3 got min=%h max=%h span=%h", ifu.xmin, ifu.xmax, ifu.xspan);
        end
    endtask

    task automatic test_boundary;
        int d;
        idle(9, d);
        step(1'b1, 2'd0, 14'd50, 1'b0);
        vecs++;
        if ({ifu.done, ifu.seen, ifu.xmin[13:0], ifu.xmax[13:0]} !== {1'b1, 4'b0001, 14'd50, 14'd50}) begin
            errs++;
            $display("FAIL boundary_first got done=%b seen=%b min=%0d max=%0d", ifu.done, ifu.seen, ifu.xmin[13:0], ifu.xmax[13:0]);
        end
        step(1'b1, 2'd0, 14'd60, 1'b0);
        vecs++;
        if ({ifu.done, ifu.xmax[13:0]} !== {1'b0, 14'd50}) begin
            errs++;
            $display("FAIL boundary_hold got done=%b max=%0d exp 0/50", ifu.done, ifu.xmax[13:0]);
        end
        idle(8, d);
        step(1'b0, 2'd0, '0, 1'b0);
        vecs++;
        if ({ifu.done, ifu.xmin[13:0], ifu.xmax[13:0]} !== {1'b1, 14'd60, 14'd60}) begin
            errs++;
            $display("FAIL boundary_second got done=%b min=%0d max=%0d", ifu.done, ifu.xmin[13:0], ifu.xmax[13:0]);
        end
    endtask

    task automatic test_clear;
        int d;
        idle(9, d);
        step(1'b1, 2'd0, 14'd77, 1'b1);
        vecs++;
        if ({ifu.done, ifu.seen, ifu.xmin[13:0]} !== {1'b0, 4'b0001, 14'd60}) begin
            errs++;
            $display("FAIL clear_at_end got done=%b seen=%b min=%0d exp 0/0001/60", ifu.done, ifu.seen, ifu.xmin[13:0]);
        end
        idle(9, d);
        vecs++;
        if (d !== 0) begin errs++; $display("FAIL clear_early_done got %0d pulses exp 0", d); end
        step(1'b0, 2'd0, '0, 1'b0);
        vecs++;
        if ({ifu.done, ifu.seen, ifu.xmin, ifu.xmax} !== {1'b1, 4'b0000, 56'd0, 56'd0}) begin
            errs++;
            $display("FAIL clear_next_window got done=%b seen=%b min=%h", ifu.done, ifu.seen, ifu.xmin);
        end
    endtask

    task automatic test_period_change;
        int d;
        period = 16'd100;
        step(1'b1, 2'd2, 14'd33, 1'b0);
        idle(39, d);
        vecs++;
        if (d !== 0) begin errs++; $display("FAIL period_early_done got %0d pulses exp 0", d); end
        period = 16'd20;
        step(1'b0, 2'd0, '0, 1'b0);
        vecs++;
        if ({ifu.done, ifu.seen, ifu.xmin[41:28]} !== {1'b1, 4'b0100, 14'd33}) begin
            errs++;
            $display("FAIL period_drop got done=%b seen=%b min=%0d", ifu.done, ifu.seen, ifu.xmin[41:28]);
        end
        period = 16'd9;
        idle(5, d);
        vecs++;
        if (d !== 0) begin errs++; $display("FAIL period_single_done got %0d extra pulses exp 0", d); end
    endtask

    task automatic test_async_reset;
        int d;
        #2;
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({ifu.xmin, ifu.xmax, ifu.xspan, ifu.seen, ifu.done} !== '0) begin
            errs++;
            $display("FAIL async_reset got xmin=%h seen=%b exp zero", ifu.xmin, ifu.seen);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(9, d);
        vecs++;
        if (d !== 0) begin errs++; $display("FAIL reset_early_done got %0d pulses exp 0", d); end
        step(1'b0, 2'd0, '0, 1'b0);
        vecs++;
        if ({ifu.done, ifu.seen} !== {1'b1, 4'b0000}) begin
            errs++;
            $display("FAIL reset_first_done got done=%b seen=%b exp 1/0000", ifu.done, ifu.seen);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_boundary();
        test_clear();
        test_period_change();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
